// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch port for instr_sequencer.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, held until imem_ack
//   imem_ack   : fetch complete, imem_rdata valid in the same cycle
//   imem_rdata : fetched 32-bit instruction word
// master = sequencer side, slave = memory side.
interface instr_sequencer_if #(
  parameter int unsigned PC_WIDTH = 8
) ();
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer. Owns the program counter, fetches instruction words
// over the imem handshake into the instruction register, and steps each instruction
// through FETCH -> DECODE -> EXECUTE (EXEC_CYCLES) -> WRITEBACK, opening the register-file
// write enables only during WRITEBACK.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, start_pc     : begin execution at start_pc (accepted in IDLE or HALT)
//   stop                : return to IDLE at the next instruction boundary
//   imem                : fetch port (master side)
//   instruction         : instruction register, to the controller
//   we1_dec, we2_dec    : decoded write enables from the controller
//   WE1, WE2            : gated write enables to the register file
//   pc                  : program counter
//   busy, halted        : state decodes
//   instr_count         : retired instructions, saturating
module instr_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                stop,
  instr_sequencer_if.master   imem,
  output logic [31:0]         instruction,
  input  logic                we1_dec,
  input  logic                we2_dec,
  output logic                WE1,
  output logic                WE2,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         instr_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  // Counter holds the remaining EXECUTE cycles after the current one.
  localparam logic [3:0] ExecLoad = 4'(EXEC_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [15:0]         count_q, count_d;
  logic                stop_q, stop_d;
  logic [3:0]          exec_cnt_q, exec_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      instr_q    <= '0;
      count_q    <= '0;
      stop_q     <= 1'b0;
      exec_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      stop_q     <= stop_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    stop_d     = stop_q;
    exec_cnt_d = exec_cnt_q;

    unique case (state_q)
      StIdle, StHalt: begin
        // A stop arriving with start is dropped.
        if (start) begin
          state_d = StFetch;
          pc_d    = start_pc;
          count_d = '0;
          stop_d  = 1'b0;
        end
      end
      StFetch: begin
        if (stop) stop_d = 1'b1;
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = (imem.imem_rdata == HALT_WORD) ? StHalt : StDecode;
        end
      end
      StDecode: begin
        if (stop) stop_d = 1'b1;
        exec_cnt_d = ExecLoad;
        state_d    = StExecute;
      end
      StExecute: begin
        if (stop) stop_d = 1'b1;
        if (exec_cnt_q == 4'd0) begin
          state_d = StWriteback;
        end else begin
          exec_cnt_d = exec_cnt_q - 4'd1;
        end
      end
      StWriteback: begin
        pc_d    = pc_q + PcOne;
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        state_d = (stop_q || stop) ? StIdle : StFetch;
        // The stop request is consumed at this boundary either way.
        stop_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state_q == StFetch);
    imem.imem_addr = (state_q == StFetch) ? pc_q : '0;
    // Reset also blocks the enables combinationally so a WRITEBACK cut short by reset
    // never reaches the register file.
    WE1            = (state_q == StWriteback) && we1_dec && !reset;
    WE2            = (state_q == StWriteback) && we2_dec && !reset;
    busy           = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StExecute) || (state_q == StWriteback);
    halted         = (state_q == StHalt);
    instruction    = instr_q;
    pc             = pc_q;
    instr_count    = count_q;
  end

endmodule
